// File: rtl/hall_decoder.sv
// Hall-sensor commutation decoder: synchronizes and debounces the 3-bit hall code,
// tracks sector, direction and signed position, and measures the interval between steps.
module hall_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int COUNT_WIDTH   = 16,
    parameter int PERIOD_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [2:0]              h,
    input  logic                    enable,
    input  logic                    fault_clear,
    output logic [2:0]              sector,
    output logic                    sector_valid,
    output logic                    direction,
    output logic [COUNT_WIDTH-1:0]  position,
    output logic                    edge_pulse,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    stall,
    output logic                    hall_fault
);

    typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;

    localparam int                      FILT_W     = $clog2(FILTER_CYCLES + 1);
    localparam logic [FILT_W-1:0]       FILT_DONE  = FILT_W'(FILTER_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

    logic [2:0]              r_sync [SYNC_STAGES];
    logic [2:0]              r_cand;
    logic [FILT_W-1:0]       r_filt_cnt;
    state_t                  r_state;
    logic [2:0]              r_sector;
    logic                    r_direction;
    logic [COUNT_WIDTH-1:0]  r_position;
    logic                    r_edge_pulse;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic                    r_period_valid;
    logic [PERIOD_WIDTH-1:0] r_period_cnt;
    logic                    r_first_step;

    logic [2:0] w_sync;
    logic       w_accept;
    logic       w_code_valid;
    logic [2:0] w_code_sector;
    logic [2:0] w_fwd_sector;
    logic [2:0] w_rev_sector;
    logic       w_is_fwd;
    logic       w_is_rev;
    logic       w_same;

    // NOTE: the synchronizer chain is a plain register array, so it is cleared in reset like any other flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= h;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Accept fires exactly once, on the FILTER_CYCLES-th consecutive cycle a new value is seen.
    assign w_accept = (w_sync != r_cand) ? (FILTER_CYCLES == 1)
                                         : (r_filt_cnt == FILT_DONE - FILT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cand     <= '0;
            r_filt_cnt <= FILT_DONE;
        end else if (w_sync != r_cand) begin
            r_cand     <= w_sync;
            r_filt_cnt <= FILT_W'(1);
        end else if (r_filt_cnt != FILT_DONE) begin
            r_filt_cnt <= r_filt_cnt + FILT_W'(1);
        end
    end

    always_comb begin
        w_code_valid  = 1'b1;
        w_code_sector = 3'd0;
        case (w_sync)
            3'b101:  w_code_sector = 3'd0;
            3'b100:  w_code_sector = 3'd1;
            3'b110:  w_code_sector = 3'd2;
            3'b010:  w_code_sector = 3'd3;
            3'b011:  w_code_sector = 3'd4;
            3'b001:  w_code_sector = 3'd5;
            default: w_code_valid  = 1'b0;
        endcase
    end

    assign w_fwd_sector = (r_sector == 3'd5) ? 3'd0 : r_sector + 3'd1;
    assign w_rev_sector = (r_sector == 3'd0) ? 3'd5 : r_sector - 3'd1;
    assign w_is_fwd     = w_code_valid && (w_code_sector == w_fwd_sector);
    assign w_is_rev     = w_code_valid && (w_code_sector == w_rev_sector);
    assign w_same       = w_code_valid && (w_code_sector == r_sector);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_INIT;
            r_sector       <= '0;
            r_direction    <= 1'b0;
            r_position     <= '0;
            r_edge_pulse   <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_period_cnt   <= '0;
            r_first_step   <= 1'b1;
        end else begin
            r_edge_pulse   <= 1'b0;
            r_period_valid <= 1'b0;
            if (!enable) begin
                r_state      <= ST_INIT;
                r_period_cnt <= '0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        if (w_accept) begin
                            if (w_code_valid) begin
                                r_sector     <= w_code_sector;
                                r_state      <= ST_TRACK;
                                r_period_cnt <= '0;
                                r_first_step <= 1'b1;
                            end else begin
                                r_state <= ST_FAULT;
                            end
                        end
                    end
                    ST_TRACK: begin
                        if (r_period_cnt != PERIOD_MAX) r_period_cnt <= r_period_cnt + PERIOD_WIDTH'(1);
                        if (w_accept && !w_same) begin
                            if (w_is_fwd || w_is_rev) begin
                                r_sector     <= w_code_sector;
                                r_direction  <= w_is_fwd;
                                r_position   <= w_is_fwd ? r_position + COUNT_WIDTH'(1)
                                                         : r_position - COUNT_WIDTH'(1);
                                r_edge_pulse <= 1'b1;
                                r_period_cnt <= '0;
                                r_first_step <= 1'b0;
                                // The first step after entering TRACK has no valid start point to time from.
                                if (!r_first_step) begin
                                    r_period       <= (r_period_cnt == PERIOD_MAX) ? PERIOD_MAX
                                                                                   : r_period_cnt + PERIOD_WIDTH'(1);
                                    r_period_valid <= 1'b1;
                                end
                            end else begin
                                r_state <= ST_FAULT;
                            end
                        end
                    end
                    ST_FAULT: begin
                        if (fault_clear) r_state <= ST_INIT;
                    end
                    default: r_state <= ST_INIT;
                endcase
            end
        end
    end

    assign sector       = r_sector;
    assign sector_valid = (r_state == ST_TRACK);
    assign hall_fault   = (r_state == ST_FAULT);
    assign direction    = r_direction;
    assign position     = r_position;
    assign edge_pulse   = r_edge_pulse;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign stall        = (r_period_cnt == PERIOD_MAX);

endmodule

// File: tb/tb_hall_decoder.sv
// Directed, table-driven bench for hall_decoder with default parameters.
module tb_hall_decoder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  h;
    logic        enable;
    logic        fault_clear;
    logic [2:0]  sector;
    logic        sector_valid;
    logic        direction;
    logic [15:0] position;
    logic        edge_pulse;
    logic [15:0] period;
    logic        period_valid;
    logic        stall;
    logic        hall_fault;

    hall_decoder dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .h            (h),
        .enable       (enable),
        .fault_clear  (fault_clear),
        .sector       (sector),
        .sector_valid (sector_valid),
        .direction    (direction),
        .position     (position),
        .edge_pulse   (edge_pulse),
        .period       (period),
        .period_valid (period_valid),
        .stall        (stall),
        .hall_fault   (hall_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  code;
        int          hold;
        logic [2:0]  sec;
        logic [15:0] pos;
        logic        dir;
        int          edges;
        int          pvs;
        logic [15:0] per;
    } vec_t;

    vec_t        vecs [13];
    int          checks = 0;
    int          errors = 0;
    int          n_edges;
    int          n_pvs;
    logic [15:0] last_period;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_edges     = 0;
        n_pvs       = 0;
        last_period = '0;
    endtask

    // Drive a code (called at a falling edge) and observe n falling edges.
    task automatic hold(input logic [2:0] code, input int n);
        h = code;
        repeat (n) begin
            @(negedge clock);
            if (edge_pulse)   n_edges++;
            if (period_valid) begin
                n_pvs++;
                last_period = period;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " sector"},       {29'd0, sector}, 32'd0);
        check({tag, " sector_valid"}, {31'd0, sector_valid}, 32'd0);
        check({tag, " direction"},    {31'd0, direction}, 32'd0);
        check({tag, " position"},     {16'd0, position}, 32'd0);
        check({tag, " period"},       {16'd0, period}, 32'd0);
        check({tag, " period_valid"}, {31'd0, period_valid}, 32'd0);
        check({tag, " edge_pulse"},   {31'd0, edge_pulse}, 32'd0);
        check({tag, " stall"},        {31'd0, stall}, 32'd0);
        check({tag, " hall_fault"},   {31'd0, hall_fault}, 32'd0);
    endtask

    task automatic run_row(input int i);
        string t;
        t = $sformatf("row%0d", i);
        clear_counts();
        hold(vecs[i].code, vecs[i].hold);
        check({t, " sector"},       {29'd0, sector}, {29'd0, vecs[i].sec});
        check({t, " sector_valid"}, {31'd0, sector_valid}, 32'd1);
        check({t, " hall_fault"},   {31'd0, hall_fault}, 32'd0);
        check({t, " position"},     {16'd0, position}, {16'd0, vecs[i].pos});
        check({t, " direction"},    {31'd0, direction}, {31'd0, vecs[i].dir});
        check({t, " edge_pulses"},  n_edges, vecs[i].edges);
        check({t, " period_pulses"}, n_pvs, vecs[i].pvs);
        if (vecs[i].pvs != 0) check({t, " period"}, {16'd0, last_period}, {16'd0, vecs[i].per});
        check({t, " stall"},        {31'd0, stall}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{3'b101, 1000, 3'd0, 16'h0000, 1'b0, 0, 0, 16'd0};
        vecs[1]  = '{3'b100, 1000, 3'd1, 16'h0001, 1'b1, 1, 0, 16'd0};
        vecs[2]  = '{3'b110, 1000, 3'd2, 16'h0002, 1'b1, 1, 1, 16'd1000};
        vecs[3]  = '{3'b010, 1000, 3'd3, 16'h0003, 1'b1, 1, 1, 16'd1000};
        vecs[4]  = '{3'b011, 1000, 3'd4, 16'h0004, 1'b1, 1, 1, 16'd1000};
        vecs[5]  = '{3'b001, 1000, 3'd5, 16'h0005, 1'b1, 1, 1, 16'd1000};
        vecs[6]  = '{3'b101, 1000, 3'd0, 16'h0006, 1'b1, 1, 1, 16'd1000};
        vecs[7]  = '{3'b101,  500, 3'd0, 16'h0000, 1'b0, 0, 0, 16'd0};
        vecs[8]  = '{3'b001,  500, 3'd5, 16'hFFFF, 1'b0, 1, 0, 16'd0};
        vecs[9]  = '{3'b011,  500, 3'd4, 16'hFFFE, 1'b0, 1, 1, 16'd500};
        vecs[10] = '{3'b010,  500, 3'd3, 16'hFFFD, 1'b0, 1, 1, 16'd65535};
        vecs[11] = '{3'b110,  500, 3'd2, 16'hFFFC, 1'b0, 1, 1, 16'd500};
        vecs[12] = '{3'b100,   20, 3'd1, 16'hFFFB, 1'b0, 1, 1, 16'd500};

        reset_n     = 1'b0;
        h           = 3'b101;
        enable      = 1'b1;
        fault_clear = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;

        for (int i = 0; i <= 6; i++) run_row(i);

        // Three-cycle glitch must be rejected by the filter.
        clear_counts();
        hold(3'b100, 3);
        hold(3'b101, 30);
        check("glitch edge_pulses", n_edges, 0);
        check("glitch sector", {29'd0, sector}, 32'd0);
        check("glitch position", {16'd0, position}, 32'd6);

        // Asynchronous reset between clock edges.
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int i = 7; i <= 9; i++) run_row(i);

        // Period counter saturation: counter hits 65535 at falling edge 65541 after the code change.
        clear_counts();
        hold(3'b011, 65040);
        check("stall before saturation", {31'd0, stall}, 32'd0);
        hold(3'b011, 1);
        check("stall at saturation", {31'd0, stall}, 32'd1);
        hold(3'b011, 4459);
        check("stall held", {31'd0, stall}, 32'd1);
        check("stall hold edge_pulses", n_edges, 0);

        for (int i = 10; i <= 12; i++) run_row(i);

        // Invalid code in TRACK at sector 1.
        clear_counts();
        hold(3'b111, 20);
        check("fault hall_fault", {31'd0, hall_fault}, 32'd1);
        check("fault sector_valid", {31'd0, sector_valid}, 32'd0);
        check("fault position", {16'd0, position}, 32'h0000FFFB);
        check("fault sector", {29'd0, sector}, 32'd1);
        check("fault edge_pulses", n_edges, 0);

        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        check("clear hall_fault", {31'd0, hall_fault}, 32'd0);
        check("clear sector_valid", {31'd0, sector_valid}, 32'd0);

        clear_counts();
        hold(3'b110, 20);
        check("reacquire sector", {29'd0, sector}, 32'd2);
        check("reacquire sector_valid", {31'd0, sector_valid}, 32'd1);
        check("reacquire position", {16'd0, position}, 32'h0000FFFB);
        check("reacquire edge_pulses", n_edges, 0);
        check("reacquire period_pulses", n_pvs, 0);

        fault_clear = 1'b1;
        @(negedge clock);
        fault_clear = 1'b0;
        check("stray fault_clear sector_valid", {31'd0, sector_valid}, 32'd1);

        // Disable forces INIT; re-enable needs a fresh accepted code.
        enable = 1'b0;
        hold(3'b110, 5);
        check("disabled sector_valid", {31'd0, sector_valid}, 32'd0);
        check("disabled position", {16'd0, position}, 32'h0000FFFB);
        enable = 1'b1;
        hold(3'b110, 10);
        check("reenabled idle sector_valid", {31'd0, sector_valid}, 32'd0);
        clear_counts();
        hold(3'b010, 20);
        check("reenabled sector", {29'd0, sector}, 32'd3);
        check("reenabled sector_valid", {31'd0, sector_valid}, 32'd1);
        check("reenabled position", {16'd0, position}, 32'h0000FFFB);
        check("reenabled edge_pulses", n_edges, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
